// File: rtl/ff_bank_pkg.sv
// ff_bank_pkg: shared types and constants for the ff_bank register primitive.
//   ff_mode_e  - per-edge update mode shared by every bit of the bank.
//   POL_*      - response of an SR-mode bit to S=R=1.
package ff_bank_pkg;

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } ff_mode_e;

  localparam logic [1:0] POL_HOLD = 2'd0;
  localparam logic [1:0] POL_SET  = 2'd1;
  localparam logic [1:0] POL_RST  = 2'd2;

endpackage

// File: rtl/ff_bit_cell.sv
// ff_bit_cell: combinational next-state and conflict flag for one bank bit.
// Ports:
//   mode     - SR / JK / D / T select
//   a, b     - S/R, J/K, D, T inputs (b unused in D and T)
//   q        - current registered state of this bit
//   policy   - SR forbidden-input response (POL_HOLD / POL_SET / POL_RST)
//   q_next   - state to load on an enabled edge
//   conflict - 1 when SR mode sees a=b=1
module ff_bit_cell
  import ff_bank_pkg::*;
(
  input  ff_mode_e   mode,
  input  logic       a,
  input  logic       b,
  input  logic       q,
  input  logic [1:0] policy,
  output logic       q_next,
  output logic       conflict
);

  always_comb begin
    q_next   = q;
    conflict = 1'b0;
    unique case (mode)
      MODE_SR: begin
        unique case ({a, b})
          2'b01:   q_next = 1'b0;
          2'b10:   q_next = 1'b1;
          2'b11: begin
            conflict = 1'b1;
            // Unknown policy codes fall back to hold so no X can appear.
            unique case (policy)
              POL_SET: q_next = 1'b1;
              POL_RST: q_next = 1'b0;
              default: q_next = q;
            endcase
          end
          default: q_next = q;
        endcase
      end
      MODE_JK: begin
        unique case ({a, b})
          2'b01:   q_next = 1'b0;
          2'b10:   q_next = 1'b1;
          2'b11:   q_next = ~q;
          default: q_next = q;
        endcase
      end
      MODE_D:  q_next = a;
      MODE_T:  q_next = q ^ a;
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/ff_bank.sv
// ff_bank: WIDTH-bit multi-mode (SR/JK/D/T) flop bank with conflict tracking.
// Ports:
//   clk, rst_n      - rising-edge clock, asynchronous active-low reset
//   en              - clock enable; 0 holds state and forces conflict to 0
//   mode            - 00 SR, 01 JK, 10 D, 11 T
//   a, b            - per-bit flop inputs
//   clr_sticky      - synchronous clear of conflict_sticky (and conflict_cnt)
//   q, qbar         - flop state and its exact complement
//   conflict        - registered per-bit SR forbidden-input flag
//   conflict_sticky - set on any conflict, held until clr_sticky
//   conflict_cnt    - saturating count of conflict cycles
//                     (only when FF_BANK_CONFLICT_CNT_EN is defined)
module ff_bank
  import ff_bank_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RST_VAL   = '0,
  parameter int unsigned      SR_POLICY = 0,
  parameter int unsigned      CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_sticky,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] conflict,
  output logic             conflict_sticky
`ifdef FF_BANK_CONFLICT_CNT_EN
  ,
  output logic [CNT_W-1:0] conflict_cnt
`endif
);

  if (WIDTH < 1 || WIDTH > 64 || CNT_W < 1) begin : gen_param_err
    $error("ff_bank: WIDTH must be 1..64 and CNT_W at least 1");
  end

  // Policy code 3 (or anything else) degrades to hold.
  localparam logic [1:0] Policy = (SR_POLICY == 1) ? POL_SET :
                                  (SR_POLICY == 2) ? POL_RST : POL_HOLD;

  ff_mode_e         mode_sel;
  logic [WIDTH-1:0] q_q, q_d, q_next;
  logic [WIDTH-1:0] conflict_q, conflict_d, conflict_next;
  logic             sticky_q, sticky_d;

  assign mode_sel = ff_mode_e'(mode);

  for (genvar i = 0; i < WIDTH; i++) begin : gen_cell
    ff_bit_cell u_cell (
      .mode     (mode_sel),
      .a        (a[i]),
      .b        (b[i]),
      .q        (q_q[i]),
      .policy   (Policy),
      .q_next   (q_next[i]),
      .conflict (conflict_next[i])
    );
  end

  always_comb begin
    q_d        = en ? q_next : q_q;
    conflict_d = en ? conflict_next : '0;
    // A new conflict beats a same-edge clear.
    sticky_d   = (sticky_q & ~clr_sticky) | (|conflict_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q        <= RST_VAL;
      conflict_q <= '0;
      sticky_q   <= 1'b0;
    end else begin
      q_q        <= q_d;
      conflict_q <= conflict_d;
      sticky_q   <= sticky_d;
    end
  end

  assign q               = q_q;
  assign qbar            = ~q_q;
  assign conflict        = conflict_q;
  assign conflict_sticky = sticky_q;

`ifdef FF_BANK_CONFLICT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = clr_sticky ? '0 : cnt_q;
    // One count per conflict cycle regardless of how many bits collided.
    if ((|conflict_d) && (cnt_d != {CNT_W{1'b1}})) begin
      cnt_d = cnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign conflict_cnt = cnt_q;
`endif

endmodule
